// File: rtl/ray_setup.sv
// ---------------------------------------------------------------------------
// ray_setup
//
// Per-column ray setup for a grid ray caster. For one screen column it
// derives the camera-space x coordinate, the ray direction, the per-axis
// step sign and the per-axis DDA delta |1/ray_dir|, all in Q8.8.
// One ray is accepted at a time; results appear with fixed latency and are
// held on the outputs until the next ray completes.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   ray_fed    in   start request, only looked at while idle
//   ray_index  in   [9:0]  screen column (nominally 0..639)
//   dir_x/y    in   [15:0] signed Q8.8 player direction
//   plane_x/y  in   [15:0] signed Q8.8 camera plane
//   ray_dir_x/y out [15:0] signed Q8.8 ray direction
//   delta_x/y  out [15:0] unsigned Q8.8 |1/ray_dir|, saturated to 0xFFFF
//   step_x/y   out  1 = negative direction component
//   ray_valid  out  single-cycle pulse, results valid in that cycle
//   busy       out  high whenever a ray is in flight
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for ray_fed; inputs captured on acceptance
// CAM   | camera_x = clamp(((idx - 320) * 205) >>> 8, -256, 256)
// MUL   | ray_dir = dir + ((plane * camera_x) >>> 8), divisor magnitudes
// DIV   | 17 restoring-division steps of 65536 / |ray_dir|, both axes
// DONE  | results on outputs, ray_valid high for this one cycle
// ---------------------------------------------------------------------------
module ray_setup (
    input  logic        clk,
    input  logic        reset,
    input  logic        ray_fed,
    input  logic [9:0]  ray_index,
    input  logic [15:0] dir_x,
    input  logic [15:0] dir_y,
    input  logic [15:0] plane_x,
    input  logic [15:0] plane_y,
    output logic [15:0] ray_dir_x,
    output logic [15:0] ray_dir_y,
    output logic [15:0] delta_x,
    output logic [15:0] delta_y,
    output logic        step_x,
    output logic        step_y,
    output logic        ray_valid,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CAM  = 3'd1,
        MUL  = 3'd2,
        DIV  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t state_q;

    // captured ray inputs
    logic [9:0]  idx_q;
    logic [15:0] dir_x_q;
    logic [15:0] dir_y_q;
    logic [15:0] plane_x_q;
    logic [15:0] plane_y_q;

    // pipeline intermediates
    logic signed [9:0] cam_q;
    logic [15:0] rdx_q;
    logic [15:0] rdy_q;

    // divider state
    logic [4:0]  cnt_q;
    logic [15:0] dsr_x_q;
    logic [15:0] dsr_y_q;
    logic [15:0] rem_x_q;
    logic [15:0] rem_y_q;
    logic [15:0] quo_x_q;
    logic [15:0] quo_y_q;
    logic        sat_x_q;
    logic        sat_y_q;

    // registered outputs
    logic [15:0] ray_dir_x_q;
    logic [15:0] ray_dir_y_q;
    logic [15:0] delta_x_q;
    logic [15:0] delta_y_q;
    logic        step_x_q;
    logic        step_y_q;
    logic        ray_valid_q;
    logic        busy_q;

    // -----------------------------------------------------------------------
    // CAM: camera_x from the column index
    // -----------------------------------------------------------------------
    logic signed [19:0] idx_off;
    logic signed [19:0] cam_prod;
    logic signed [19:0] cam_shr;
    logic signed [9:0]  cam_d;

    assign idx_off  = $signed({10'd0, idx_q}) - 20'sd320;
    assign cam_prod = idx_off * 20'sd205;
    assign cam_shr  = cam_prod >>> 8;

    // Out-of-range indices (up to 1023) land well past +256, so the clamp
    // is what bounds them.
    always_comb begin
        cam_d = cam_shr[9:0];
        if (cam_shr < -20'sd256) begin
            cam_d = -10'sd256;
        end else if (cam_shr > 20'sd256) begin
            cam_d = 10'sd256;
        end
    end

    // -----------------------------------------------------------------------
    // MUL: ray direction and divisor magnitude
    // -----------------------------------------------------------------------
    logic signed [25:0] cam_w;
    logic signed [25:0] px_w;
    logic signed [25:0] py_w;
    logic signed [25:0] prod_x;
    logic signed [25:0] prod_y;
    logic [15:0] shr_x;
    logic [15:0] shr_y;
    logic [15:0] rdx_d;
    logic [15:0] rdy_d;
    logic [15:0] mag_x_d;
    logic [15:0] mag_y_d;

    assign cam_w  = {{16{cam_q[9]}}, cam_q};
    assign px_w   = {{10{plane_x_q[15]}}, plane_x_q};
    assign py_w   = {{10{plane_y_q[15]}}, plane_y_q};
    assign prod_x = px_w * cam_w;
    assign prod_y = py_w * cam_w;
    assign shr_x  = 16'(prod_x >>> 8);
    assign shr_y  = 16'(prod_y >>> 8);

    // Sum wraps modulo 2^16; no saturation on the direction itself.
    assign rdx_d  = dir_x_q + shr_x;
    assign rdy_d  = dir_y_q + shr_y;

    // Negating 0x8000 yields 0x8000, which read as unsigned is the magnitude.
    assign mag_x_d = rdx_d[15] ? (16'd0 - rdx_d) : rdx_d;
    assign mag_y_d = rdy_d[15] ? (16'd0 - rdy_d) : rdy_d;

    // -----------------------------------------------------------------------
    // DIV: one restoring step per cycle, dividend fixed at 65536
    // -----------------------------------------------------------------------
    // The dividend has a single set bit (bit 16), which enters on the first
    // step; every later step shifts in a zero.
    logic        div_bit;
    logic [16:0] rem_sh_x;
    logic [16:0] rem_sh_y;
    logic        ge_x;
    logic        ge_y;
    logic [15:0] diff_x;
    logic [15:0] diff_y;
    logic [15:0] rem_x_d;
    logic [15:0] rem_y_d;
    logic [15:0] quo_x_d;
    logic [15:0] quo_y_d;
    logic        sat_x_d;
    logic        sat_y_d;
    logic [15:0] delta_x_d;
    logic [15:0] delta_y_d;

    assign div_bit  = (cnt_q == 5'd16);
    assign rem_sh_x = {rem_x_q, div_bit};
    assign rem_sh_y = {rem_y_q, div_bit};
    assign ge_x     = (rem_sh_x >= {1'b0, dsr_x_q});
    assign ge_y     = (rem_sh_y >= {1'b0, dsr_y_q});
    // When ge holds, the true difference is below the divisor, so 16 bits
    // of the subtraction are exact.
    assign diff_x   = rem_sh_x[15:0] - dsr_x_q;
    assign diff_y   = rem_sh_y[15:0] - dsr_y_q;
    assign rem_x_d  = ge_x ? diff_x : rem_sh_x[15:0];
    assign rem_y_d  = ge_y ? diff_y : rem_sh_y[15:0];

    // Quotient is 17 bits wide; the bit that would fall off the top of the
    // 16-bit register becomes a sticky saturation flag.
    assign quo_x_d  = {quo_x_q[14:0], ge_x};
    assign quo_y_d  = {quo_y_q[14:0], ge_y};
    assign sat_x_d  = sat_x_q | quo_x_q[15];
    assign sat_y_d  = sat_y_q | quo_y_q[15];

    assign delta_x_d = ((dsr_x_q == 16'd0) || sat_x_d) ? 16'hFFFF : quo_x_d;
    assign delta_y_d = ((dsr_y_q == 16'd0) || sat_y_d) ? 16'hFFFF : quo_y_d;

    // -----------------------------------------------------------------------
    // Controller
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            dir_x_q     <= '0;
            dir_y_q     <= '0;
            plane_x_q   <= '0;
            plane_y_q   <= '0;
            cam_q       <= '0;
            rdx_q       <= '0;
            rdy_q       <= '0;
            cnt_q       <= '0;
            dsr_x_q     <= '0;
            dsr_y_q     <= '0;
            rem_x_q     <= '0;
            rem_y_q     <= '0;
            quo_x_q     <= '0;
            quo_y_q     <= '0;
            sat_x_q     <= 1'b0;
            sat_y_q     <= 1'b0;
            ray_dir_x_q <= '0;
            ray_dir_y_q <= '0;
            delta_x_q   <= '0;
            delta_y_q   <= '0;
            step_x_q    <= 1'b0;
            step_y_q    <= 1'b0;
            ray_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ray_fed) begin
                        idx_q     <= ray_index;
                        dir_x_q   <= dir_x;
                        dir_y_q   <= dir_y;
                        plane_x_q <= plane_x;
                        plane_y_q <= plane_y;
                        busy_q    <= 1'b1;
                        state_q   <= CAM;
                    end
                end
                CAM: begin
                    cam_q   <= cam_d;
                    state_q <= MUL;
                end
                MUL: begin
                    rdx_q   <= rdx_d;
                    rdy_q   <= rdy_d;
                    dsr_x_q <= mag_x_d;
                    dsr_y_q <= mag_y_d;
                    rem_x_q <= '0;
                    rem_y_q <= '0;
                    quo_x_q <= '0;
                    quo_y_q <= '0;
                    sat_x_q <= 1'b0;
                    sat_y_q <= 1'b0;
                    cnt_q   <= 5'd16;
                    state_q <= DIV;
                end
                DIV: begin
                    rem_x_q <= rem_x_d;
                    rem_y_q <= rem_y_d;
                    quo_x_q <= quo_x_d;
                    quo_y_q <= quo_y_d;
                    sat_x_q <= sat_x_d;
                    sat_y_q <= sat_y_d;
                    cnt_q   <= cnt_q - 5'd1;
                    if (cnt_q == 5'd0) begin
                        ray_dir_x_q <= rdx_q;
                        ray_dir_y_q <= rdy_q;
                        step_x_q    <= rdx_q[15];
                        step_y_q    <= rdy_q[15];
                        delta_x_q   <= delta_x_d;
                        delta_y_q   <= delta_y_d;
                        ray_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    ray_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: begin
                    ray_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign ray_dir_x = ray_dir_x_q;
    assign ray_dir_y = ray_dir_y_q;
    assign delta_x   = delta_x_q;
    assign delta_y   = delta_y_q;
    assign step_x    = step_x_q;
    assign step_y    = step_y_q;
    assign ray_valid = ray_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_ray_setup.sv
// ---------------------------------------------------------------------------
// tb_ray_setup
//
// Drives ray_setup with directed and random rays and compares every result
// against an integer-arithmetic reference of the ray setup rules.
// ---------------------------------------------------------------------------
module tb_ray_setup;

    logic        clk = 1'b0;
    logic        reset;
    logic        ray_fed;
    logic [9:0]  ray_index;
    logic [15:0] dir_x;
    logic [15:0] dir_y;
    logic [15:0] plane_x;
    logic [15:0] plane_y;
    logic [15:0] ray_dir_x;
    logic [15:0] ray_dir_y;
    logic [15:0] delta_x;
    logic [15:0] delta_y;
    logic        step_x;
    logic        step_y;
    logic        ray_valid;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    ray_setup dut (
        .clk       (clk),
        .reset     (reset),
        .ray_fed   (ray_fed),
        .ray_index (ray_index),
        .dir_x     (dir_x),
        .dir_y     (dir_y),
        .plane_x   (plane_x),
        .plane_y   (plane_y),
        .ray_dir_x (ray_dir_x),
        .ray_dir_y (ray_dir_y),
        .delta_x   (delta_x),
        .delta_y   (delta_y),
        .step_x    (step_x),
        .step_y    (step_y),
        .ray_valid (ray_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] rdx;
        logic [15:0] rdy;
        logic [15:0] dlx;
        logic [15:0] dly;
        logic        sx;
        logic        sy;
    } res_t;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_delta(input logic [15:0] rd);
        int mag;
        int q;
        if (rd == 16'h0000) return 16'hFFFF;
        mag = rd[15] ? (65536 - int'(rd)) : int'(rd);
        q = 65536 / mag;
        return (q > 65535) ? 16'hFFFF : 16'(q);
    endfunction

    function automatic res_t ref_ray(input logic [9:0] idx, input logic [15:0] dx,
                                     input logic [15:0] dy, input logic [15:0] px,
                                     input logic [15:0] py);
        int   cam;
        int   rx;
        int   ry;
        res_t r;
        cam = ((int'(idx) - 320) * 205) >>> 8;
        if (cam < -256) cam = -256;
        if (cam > 256)  cam = 256;
        rx = int'($signed(dx)) + ((int'($signed(px)) * cam) >>> 8);
        ry = int'($signed(dy)) + ((int'($signed(py)) * cam) >>> 8);
        r.rdx = rx[15:0];
        r.rdy = ry[15:0];
        r.sx  = rx[15];
        r.sy  = ry[15];
        r.dlx = ref_delta(rx[15:0]);
        r.dly = ref_delta(ry[15:0]);
        return r;
    endfunction

    task automatic scramble();
        ray_index = 10'($urandom);
        dir_x     = 16'($urandom);
        dir_y     = 16'($urandom);
        plane_x   = 16'($urandom);
        plane_y   = 16'($urandom);
    endtask

    task automatic chk_res(input string tag, input res_t e);
        chk({tag, ":ray_dir_x"}, 32'(ray_dir_x), 32'(e.rdx));
        chk({tag, ":ray_dir_y"}, 32'(ray_dir_y), 32'(e.rdy));
        chk({tag, ":delta_x"},   32'(delta_x),   32'(e.dlx));
        chk({tag, ":delta_y"},   32'(delta_y),   32'(e.dly));
        chk({tag, ":step_x"},    32'(step_x),    32'(e.sx));
        chk({tag, ":step_y"},    32'(step_y),    32'(e.sy));
    endtask

    // Called just after a falling edge; presents the ray in the current cycle
    // and returns one falling edge after the valid pulse (first idle cycle).
    task automatic run_ray(input string tag, input logic [9:0] idx,
                           input logic [15:0] dx, input logic [15:0] dy,
                           input logic [15:0] px, input logic [15:0] py);
        res_t e;
        int   cyc;
        int   nbusy;
        bit   seen;
        e = ref_ray(idx, dx, dy, px, py);
        ray_index = idx;
        dir_x     = dx;
        dir_y     = dy;
        plane_x   = px;
        plane_y   = py;
        ray_fed   = 1'b1;
        @(posedge clk);
        cyc   = 0;
        nbusy = 0;
        seen  = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                ray_fed = 1'b0;
                scramble();
            end
            if (busy) nbusy++;
            if (ray_valid) seen = 1'b1;
        end
        chk({tag, ":latency"}, 32'(cyc), 32'd20);
        chk_res(tag, e);
        chk({tag, ":busy_cycles"}, 32'(nbusy), 32'd20);
        @(negedge clk);
        chk({tag, ":valid_drop"}, 32'(ray_valid), 32'd0);
        chk({tag, ":busy_drop"},  32'(busy),      32'd0);
        chk({tag, ":hold_dir_x"}, 32'(ray_dir_x), 32'(e.rdx));
        chk({tag, ":hold_dly"},   32'(delta_y),   32'(e.dly));
    endtask

    initial begin
        res_t e;
        int   cyc;
        int   nbusy;
        int   nvalid;
        int   vcyc;
        logic [15:0] dx;
        logic [15:0] dy;
        logic [15:0] px;
        logic [15:0] py;

        reset     = 1'b1;
        ray_fed   = 1'b0;
        ray_index = '0;
        dir_x     = '0;
        dir_y     = '0;
        plane_x   = '0;
        plane_y   = '0;
        repeat (3) @(negedge clk);
        chk("rst:ray_dir_x", 32'(ray_dir_x), 32'd0);
        chk("rst:ray_dir_y", 32'(ray_dir_y), 32'd0);
        chk("rst:delta_x",   32'(delta_x),   32'd0);
        chk("rst:delta_y",   32'(delta_y),   32'd0);
        chk("rst:steps",     32'({step_x, step_y}), 32'd0);
        chk("rst:valid",     32'(ray_valid), 32'd0);
        chk("rst:busy",      32'(busy),      32'd0);
        reset = 1'b0;

        // Directed rays; consecutive calls also exercise back-to-back acceptance.
        run_ray("centre", 10'd320, 16'h0100, 16'h0000, 16'h0000, 16'h00A9);
        chk("centre:spec_dly", 32'(delta_y), 32'h0000FFFF);
        chk("centre:spec_dlx", 32'(delta_x), 32'h00000100);
        run_ray("left", 10'd0, 16'h0100, 16'h0000, 16'h0000, 16'h00A9);
        chk("left:spec_rdy", 32'(ray_dir_y), 32'h0000FF57);
        chk("left:spec_dly", 32'(delta_y),   32'h00000183);
        run_ray("right", 10'd639, 16'h0100, 16'h0000, 16'h0000, 16'h00A9);
        chk("right:spec_rdy", 32'(ray_dir_y), 32'h000000A8);
        chk("right:spec_dly", 32'(delta_y),   32'h00000186);
        run_ray("sat1", 10'd320, 16'h0001, 16'h0000, 16'h0000, 16'h0000);
        chk("sat1:spec_dlx", 32'(delta_x), 32'h0000FFFF);
        run_ray("neg8000", 10'd320, 16'h8000, 16'h0000, 16'h0000, 16'h0000);
        chk("neg8000:spec_dlx", 32'(delta_x), 32'h00000002);
        chk("neg8000:spec_sx",  32'(step_x),  32'd1);
        run_ray("idx1023", 10'd1023, 16'h0100, 16'hFF00, 16'h0040, 16'h00A9);

        // A second request while busy is dropped.
        e = ref_ray(10'd320, 16'h0100, 16'h0000, 16'h0000, 16'h00A9);
        ray_index = 10'd320;
        dir_x     = 16'h0100;
        dir_y     = 16'h0000;
        plane_x   = 16'h0000;
        plane_y   = 16'h00A9;
        ray_fed   = 1'b1;
        @(posedge clk);
        nbusy  = 0;
        nvalid = 0;
        vcyc   = 0;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (c == 1) ray_fed = 1'b0;
            if (c == 5) begin
                ray_fed   = 1'b1;
                ray_index = 10'd100;
            end
            if (c == 6) ray_fed = 1'b0;
            if (busy) nbusy++;
            if (ray_valid) begin
                nvalid++;
                vcyc = c;
                chk_res("busyrej", e);
            end
        end
        chk("busyrej:valid_count", 32'(nvalid), 32'd1);
        chk("busyrej:valid_cycle", 32'(vcyc),   32'd20);
        chk("busyrej:busy_cycles", 32'(nbusy),  32'd20);

        // Reset wins over a simultaneous request.
        reset   = 1'b1;
        ray_fed = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        ray_fed = 1'b0;
        chk("rstprio:busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("rstprio:busy_after", 32'(busy), 32'd0);

        // Load outputs with a nonzero ray, then abort the next one mid-flight.
        run_ray("preabort", 10'd0, 16'h0100, 16'h0000, 16'h0000, 16'h00A9);
        ray_index = 10'd200;
        ray_fed   = 1'b1;
        @(posedge clk);
        nvalid = 0;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (c == 1)  ray_fed = 1'b0;
            if (ray_valid) nvalid++;
            if (c == 10) reset = 1'b1;
            if (c == 11) reset = 1'b0;
        end
        chk("abort:no_valid",  32'(nvalid),    32'd0);
        chk("abort:busy",      32'(busy),      32'd0);
        chk("abort:ray_dir_y", 32'(ray_dir_y), 32'd0);
        chk("abort:delta_y",   32'(delta_y),   32'd0);
        chk("abort:delta_x",   32'(delta_x),   32'd0);
        chk("abort:steps",     32'({step_x, step_y}), 32'd0);
        @(negedge clk);
        chk("abort:idle_valid", 32'(ray_valid), 32'd0);
        run_ray("postabort", 10'd0, 16'h0100, 16'h0000, 16'h0000, 16'h00A9);

        // Random rays, half with small magnitudes so deltas are not saturated.
        for (int n = 0; n < 30; n++) begin
            dx = 16'($urandom);
            dy = 16'($urandom);
            px = 16'($urandom);
            py = 16'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                dx = {{7{dx[8]}}, dx[8:0]};
                dy = {{7{dy[8]}}, dy[8:0]};
                px = {{7{px[8]}}, px[8:0]};
                py = {{7{py[8]}}, py[8:0]};
            end
            run_ray($sformatf("rnd%0d", n), 10'($urandom), dx, dy, px, py);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ray_setup.md
RAY_SETUP -- requirements
Module: ray_setup

Interface
REQ-001 SHALL have a single clock and a synchronous, active-high reset: clk (1-bit input, rising-edge clock) and reset (1-bit input, synchronous, active-high).
REQ-002 SHALL have ray_fed  input  1  start request from the ray counter stage, sampled only in IDLE.
REQ-003 SHALL have ray_index  input  10  screen column, 0..639.
REQ-004 SHALL have dir_x, dir_y  input  16 each  signed Q8.8 player direction.
REQ-005 SHALL have plane_x, plane_y  input  16 each  signed Q8.8 camera plane.
REQ-006 SHALL have ray_dir_x, ray_dir_y  output  16 each  signed Q8.8 ray direction.
REQ-007 SHALL have delta_x, delta_y  output  16 each  unsigned Q8.8 |1/ray_dir| per axis.
REQ-008 SHALL have step_x, step_y  output  1 each  1 = negative direction component.
REQ-009 SHALL have ray_valid  output  1  one-cycle pulse; all result outputs are valid in that cycle.
REQ-010 SHALL have busy  output  1  high in every state except IDLE.

Function
REQ-011 SHALL implement the states IDLE, CAM, MUL, DIV and DONE.
REQ-012 IDLE with ray_fed=1 SHALL latch ray_index, dir_x/y and plane_x/y, then go to CAM; later input changes SHALL NOT affect the current ray.
REQ-013 CAM SHALL compute camera_x = ((ray_index - 320) * 205) >>> 8 (arithmetic shift, floor), clamped to [-256, +256].
REQ-014 MUL SHALL compute ray_dir_x = dir_x + ((plane_x * camera_x) >>> 8), keeping the low 16 bits (wrap, no saturation); ray_dir_y SHALL be computed the same way from dir_y and plane_y.
REQ-015 DIV SHALL run two restoring dividers in parallel, each dividing the 17-bit dividend 65536 by |ray_dir| (16-bit magnitude), with exactly 17 iteration cycles.
REQ-016 A divisor of 0 SHALL give delta = 0xFFFF.
REQ-017 A quotient greater than 0xFFFF SHALL saturate to 0xFFFF.
REQ-018 |0x8000| SHALL be treated as 0x8000 unsigned.
REQ-019 step_x SHALL equal ray_dir_x[15], and step_y SHALL equal ray_dir_y[15].
REQ-020 DONE SHALL register all results, assert ray_valid for exactly one cycle, then return to IDLE.
REQ-021 Latency SHALL be fixed: ray_valid is high in the 20th cycle after the edge that sampled ray_fed (1 CAM + 1 MUL + 17 DIV + 1 DONE).
REQ-022 ray_fed while busy=1 SHALL be ignored, with no queuing.
REQ-023 The cycle after DONE SHALL be IDLE and SHALL accept ray_fed, giving a maximum throughput of one ray per 21 cycles.
REQ-024 Result outputs SHALL hold their values between ray_valid pulses.
REQ-025 ray_index values above 639 SHALL still be processed; the camera_x clamp bounds the result.

Reset
REQ-026 While reset=1, the FSM SHALL go to IDLE on the next edge and all outputs SHALL clear to 0 (ray_dir, delta, step, ray_valid, busy).
REQ-027 Reset SHALL take priority over ray_fed in the same cycle.
REQ-028 Reset mid-operation (CAM/MUL/DIV/DONE) SHALL abort the ray with no ray_valid pulse; the first ray_fed after reset deasserts SHALL start normally.

Verification
REQ-029 Centre ray: dir=(0x0100,0), plane=(0,0x00A9), idx=320, ray_fed pulse -> 20 cycles later ray_valid=1; ray_dir=(0x0100,0x0000); delta_x=0x0100; delta_y=0xFFFF; step=(0,0).
REQ-030 Left edge: same vectors, idx=0 -> camera_x=-256; ray_dir_y=0xFF57; step_y=1; delta_y=65536/169=0x0183.
REQ-031 Right edge: idx=639 -> camera_x=255; ray_dir_y=0x00A8; delta_y=65536/168=0x0186; step_y=0.
REQ-032 Saturation: dir=(0x0001,0), plane=0 -> delta_x=0xFFFF; dir=(0x8000,0) -> delta_x=0x0002; step_x=1.
REQ-033 Busy rejection: second ray_fed at cycle 5 with idx=100 -> exactly one ray_valid, carrying the first ray's results; busy=1 for 20 cycles.
REQ-034 Reset abort: reset asserted at cycle 10 of a ray -> no ray_valid, outputs 0, busy=0; a new ray_fed 2 cycles later -> ray_valid 20 cycles after it.
